hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Sequences the 5-stage pipeline (IF, ID, EX, ME, WB) and produces its stall, flush and forwarding controls.
- Tracks the destination register and write-enable of the instructions in EX and ME.
- Drives the HA/HB forward-mux selects used in ID.
- Inserts load-use stall bubbles and squashes IF/ID after a taken branch or jump.

Parameters:
- REG_AW, 5, register address width.
- BR_PENALTY, 2, cycles IF/ID are squashed after a taken branch (1..3).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_da  in  REG_AW  ID destination register.
- id_aa  in  REG_AW  ID source A register.
- id_ba  in  REG_AW  ID source B register.
- id_rw  in  1  ID writes the register file.
- id_md  in  2  ID result select; 2'b01 = memory load.
- id_ma  in  1  ID source A is PC (no register read).
- id_mb  in  1  ID source B is immediate (no register read).
- br_taken  in  1  EX resolved taken branch/jump (C_SELECT != 0).
- pc_hold  out  1  PC does not advance this cycle.
- ifid_hold  out  1  IF/ID register keeps its contents.
- ex_bubble  out  1  ID->EX register loads a NOP (RW=0, MW=0).
- ifid_flush  out  1  IF/ID register loads a NOP.
- ha  out  1  bus A takes the forwarded value.
- hb  out  1  bus B takes the forwarded value.
- fwd_a_sel  out  1  0 = EX result F, 1 = ME result.
- fwd_b_sel  out  1  as fwd_a_sel, for B.
- busy  out  1  FSM not in RUN.

Behaviour:
- State is held in a scoreboard with two entries, EX and ME, each {da, rw, ld}.
- Each clk edge: ME <= EX.
  - EX <= {id_da, id_rw & id_valid, id_md==2'b01}.
  - EX <= 0 instead when ex_bubble=1 or ifid_flush=1 is applied to the ID instruction.
- Register 0 is never a hazard: any match against da=0 is ignored.
- Source A is in use when id_valid & !id_ma; source B when id_valid & !id_mb.
- Forwarding is combinational:
  - ha=1 if A is in use and it matches an EX entry with rw & !ld, or any ME entry with rw.
  - The EX match has priority over ME (youngest wins); fwd_a_sel=0 for EX, 1 for ME.
  - hb and fwd_b_sel follow the same rules for source B.
- Load-use: a source in use matches the EX entry with rw & ld.
  - Assert pc_hold=1, ifid_hold=1, ex_bubble=1 for exactly 1 cycle.
  - The next cycle the load sits in ME and is forwarded with fwd_x_sel=1.
- FSM states:
  - RUN: normal issue.
    - br_taken -> FLUSH with cnt=BR_PENALTY-1; ifid_flush=1 and ex_bubble=1 this cycle.
    - Else load-use -> STALL.
  - STALL: outputs are already deasserted; scoreboard EX is the bubble.
    - Returns to RUN after 1 cycle.
    - br_taken in STALL is impossible (EX holds a bubble) and is ignored.
  - FLUSH: ifid_flush=1, ex_bubble=1, ha=hb=0.
    - cnt decrements each cycle; at cnt==0 -> RUN.
- Priority when events coincide: br_taken > load-use > forward.
  - A branch in EX cancels a simultaneous load-use stall; pc_hold stays 0 so the PC loads the target.
- During FLUSH pc_hold=0, so the PC keeps fetching from the target.
- BR_PENALTY=1: FLUSH is never entered; only the single RUN-cycle flush occurs.
- Reset (asynchronous, any time, including mid-STALL/FLUSH):
  - state=RUN, cnt=0, scoreboard cleared.
  - All outputs 0.
- Release of reset gives no spurious stall or flush.
- busy=1 in STALL and FLUSH.

Optional Feature:
- Macro HAZ_PERF_CNT_EN adds three outputs, stall_cnt[31:0], flush_cnt[31:0] and fwd_cnt[31:0]:
  - stall_cnt counts cycles with ex_bubble due to load-use.
  - flush_cnt counts cycles with ifid_flush=1.
  - fwd_cnt counts cycles with ha|hb.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Sequence "ADD r3" then "SUB r4,r3,r5" in ID -> next cycle ha=1, fwd_a_sel=0, hb=0, no stall.
- Sequence "ADD r3", independent op, then "OR r6,r2,r3" -> hb=1, fwd_b_sel=1 (ME forward).
- Sequence "LD r7" then "ADD r8,r7,r1":
  - 1 cycle of pc_hold=ifid_hold=ex_bubble=1, busy=1.
  - Next cycle ha=1, fwd_a_sel=1.
- Sequence "ADD r0,..." then "SUB r1,r0,r0" -> ha=hb=0; same for a source with id_ma=1 or id_mb=1.
- br_taken pulsed while ID holds a load-use hazard, BR_PENALTY=2:
  - ifid_flush=1 for 2 cycles and pc_hold=0 throughout.
  - No STALL; FSM back in RUN on cycle 3.
- rst_n dropped asynchronously mid-FLUSH -> all outputs 0 immediately.
  - After release, "ADD r3" then "SUB r4,r3" forwards normally; with HAZ_PERF_CNT_EN the counters read 0 after reset.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard control for a 5-stage pipeline: EX/ME scoreboard, forwarding selects, load-use stall and branch squash.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/forward event counters.
module hazard_controller #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned BR_PENALTY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_da,
  input  logic [REG_AW-1:0] id_aa,
  input  logic [REG_AW-1:0] id_ba,
  input  logic              id_rw,
  input  logic [1:0]        id_md,
  input  logic              id_ma,
  input  logic              id_mb,
  input  logic              br_taken,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ex_bubble,
  output logic              ifid_flush,
  output logic              ha,
  output logic              hb,
  output logic              fwd_a_sel,
  output logic              fwd_b_sel,
  output logic              busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       fwd_cnt
`endif
);

  localparam int unsigned      CNT_W      = 2;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(BR_PENALTY - 1);
  localparam logic [1:0]       MD_LOAD    = 2'b01;

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] da;
    logic              rw;
    logic              ld;
  } sb_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sb_t              ex_q, me_q;

  logic src_a_use, src_b_use;
  logic ex_hit_a, ex_hit_b, me_hit_a, me_hit_b;
  logic ex_fwd_a, ex_fwd_b, load_use, fwd_on;

  // Register 0 never creates a dependency
  assign src_a_use = id_valid & ~id_ma;
  assign src_b_use = id_valid & ~id_mb;
  assign ex_hit_a  = src_a_use & ex_q.rw & (ex_q.da != '0) & (ex_q.da == id_aa);
  assign ex_hit_b  = src_b_use & ex_q.rw & (ex_q.da != '0) & (ex_q.da == id_ba);
  assign me_hit_a  = src_a_use & me_q.rw & (me_q.da != '0) & (me_q.da == id_aa);
  assign me_hit_b  = src_b_use & me_q.rw & (me_q.da != '0) & (me_q.da == id_ba);
  assign ex_fwd_a  = ex_hit_a & ~ex_q.ld;
  assign ex_fwd_b  = ex_hit_b & ~ex_q.ld;
  assign load_use  = (ex_hit_a | ex_hit_b) & ex_q.ld;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ex_bubble  = 1'b0;
    ifid_flush = 1'b0;
    fwd_on     = 1'b1;
    busy       = (state_q != S_RUN);

    case (state_q)
      S_RUN: begin
        // A taken branch outranks a coincident load-use stall
        if (br_taken) begin
          ifid_flush = 1'b1;
          ex_bubble  = 1'b1;
          if (BR_PENALTY > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (load_use) begin
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          ex_bubble = 1'b1;
          state_d   = S_STALL;
        end
      end
      S_STALL: state_d = S_RUN;
      S_FLUSH: begin
        ifid_flush = 1'b1;
        ex_bubble  = 1'b1;
        fwd_on     = 1'b0;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    // Youngest producer (EX) wins over ME
    ha        = fwd_on & (ex_fwd_a | me_hit_a);
    hb        = fwd_on & (ex_fwd_b | me_hit_b);
    fwd_a_sel = fwd_on & ~ex_fwd_a & me_hit_a;
    fwd_b_sel = fwd_on & ~ex_fwd_b & me_hit_b;

    if (!rst_n) begin
      pc_hold    = 1'b0;
      ifid_hold  = 1'b0;
      ex_bubble  = 1'b0;
      ifid_flush = 1'b0;
      ha         = 1'b0;
      hb         = 1'b0;
      fwd_a_sel  = 1'b0;
      fwd_b_sel  = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard shift; squashed or bubbled ID instructions enter EX as NOPs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      me_q <= '0;
    end else begin
      me_q <= ex_q;
      if (ex_bubble | ifid_flush)
        ex_q <= '0;
      else
        ex_q <= sb_t'{da: id_da, rw: id_rw & id_valid, ld: (id_md == MD_LOAD)};
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic stall_ev;
  assign stall_ev = ex_bubble & ~ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
      if ((ha | hb) && (fwd_cnt != '1))    fwd_cnt   <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed, table-driven bench for hazard_controller (BR_PENALTY=2).
// Output vector order: {pc_hold, ifid_hold, ex_bubble, ifid_flush, ha, hb, fwd_a_sel, fwd_b_sel, busy}.
module tb_hazard_controller;

  localparam int unsigned REG_AW = 5;
  localparam logic [8:0]  FULL   = 9'h1FF;
  localparam logic [8:0]  NOBUSY = 9'h1FE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [REG_AW-1:0] id_da, id_aa, id_ba;
  logic              id_rw;
  logic [1:0]        id_md;
  logic              id_ma, id_mb, br_taken;
  logic              pc_hold, ifid_hold, ex_bubble, ifid_flush;
  logic              ha, hb, fwd_a_sel, fwd_b_sel, busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]       stall_cnt, flush_cnt, fwd_cnt;
`endif

  always #5 clk = ~clk;

  hazard_controller #(.REG_AW(REG_AW), .BR_PENALTY(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_da(id_da), .id_aa(id_aa),
    .id_ba(id_ba), .id_rw(id_rw), .id_md(id_md), .id_ma(id_ma), .id_mb(id_mb),
    .br_taken(br_taken), .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ex_bubble(ex_bubble), .ifid_flush(ifid_flush), .ha(ha), .hb(hb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .busy(busy)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  logic [8:0] outs;
  assign outs = {pc_hold, ifid_hold, ex_bubble, ifid_flush, ha, hb, fwd_a_sel, fwd_b_sel, busy};

  typedef struct {
    logic             valid;
    logic [REG_AW-1:0] da, aa, ba;
    logic             rw;
    logic [1:0]       md;
    logic             ma, mb, br;
    logic [8:0]       exp, mask;
  } vec_t;

  vec_t vecs[20];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic v, input int da, input int aa, input int ba,
                     input logic rw, input logic [1:0] md, input logic ma, input logic mb,
                     input logic br, input logic [8:0] e, input logic [8:0] m);
    vecs[nv].valid = v;
    vecs[nv].da    = REG_AW'(da);
    vecs[nv].aa    = REG_AW'(aa);
    vecs[nv].ba    = REG_AW'(ba);
    vecs[nv].rw    = rw;
    vecs[nv].md    = md;
    vecs[nv].ma    = ma;
    vecs[nv].mb    = mb;
    vecs[nv].br    = br;
    vecs[nv].exp   = e;
    vecs[nv].mask  = m;
    nv++;
  endtask

  task automatic drive(input logic v, input int da, input int aa, input int ba,
                       input logic rw, input logic [1:0] md, input logic ma, input logic mb,
                       input logic br);
    id_valid = v;
    id_da    = REG_AW'(da);
    id_aa    = REG_AW'(aa);
    id_ba    = REG_AW'(ba);
    id_rw    = rw;
    id_md    = md;
    id_ma    = ma;
    id_mb    = mb;
    br_taken = br;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp,
                       input logic [8:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: got %b required %b (mask %b)", name, act, exp, mask);
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask
`endif

  initial begin
    // valid da aa ba rw md ma mb br | expected, mask
    add(1,  3,  1,  2, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // ADD r3
    add(1,  4,  3,  5, 1, 2'b00, 0, 0, 0, 9'b000010000, FULL);   // SUB r4,r3,r5: EX fwd A
    add(1,  3,  1,  2, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // ADD r3
    add(1,  9,  1,  2, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // independent
    add(1,  6,  2,  3, 1, 2'b00, 0, 0, 0, 9'b000001010, FULL);   // OR r6,r2,r3: ME fwd B
    add(1, 10,  6,  9, 1, 2'b00, 0, 0, 0, 9'b000011010, FULL);   // A from EX, B from ME
    add(1, 10,  1,  2, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // r10 again
    add(1, 11, 10, 10, 1, 2'b00, 0, 0, 0, 9'b000011000, FULL);   // EX beats ME
    add(1,  7,  1,  0, 1, 2'b01, 0, 1, 0, 9'b000000000, FULL);   // LD r7
    add(1,  8,  7,  1, 1, 2'b00, 0, 0, 0, 9'b111000000, NOBUSY); // load-use stall
    add(1,  8,  7,  1, 1, 2'b00, 0, 0, 0, 9'b000010101, FULL);   // held: ME fwd, busy
    add(1,  0,  1,  2, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // ADD r0
    add(1,  1,  0,  0, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // SUB r1,r0,r0
    add(1,  2,  1,  1, 1, 2'b00, 1, 1, 0, 9'b000000000, FULL);   // ma/mb: no reg read
    add(0,  2,  2,  1, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // invalid ID
    add(1,  5,  2,  3, 1, 2'b00, 0, 0, 0, 9'b000010100, FULL);   // invalid did not write r2
    add(1, 12,  1,  0, 1, 2'b01, 0, 1, 0, 9'b000000000, FULL);   // LD r12
    add(1, 13, 12,  5, 1, 2'b00, 0, 0, 1, 9'b001101010, NOBUSY); // branch beats load-use
    add(1, 14, 12, 12, 1, 2'b00, 0, 0, 0, 9'b001100001, FULL);   // FLUSH, no fwd
    add(1, 15,  1,  2, 1, 2'b00, 0, 0, 0, 9'b000000000, FULL);   // back in RUN

    // Reset with an active branch request still shows all-zero outputs
    rst_n = 1'b0;
    drive(1, 3, 3, 3, 1, 2'b01, 0, 0, 1);
    #3;
    check("in_reset", outs, 9'b0, FULL);
`ifdef HAZ_PERF_CNT_EN
    check32("stall_cnt_reset", stall_cnt, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    rst_n = 1'b1;
    #2;
    check("release_idle", outs, 9'b0, FULL);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, int'(vecs[i].da), int'(vecs[i].aa), int'(vecs[i].ba), vecs[i].rw,
            vecs[i].md, vecs[i].ma, vecs[i].mb, vecs[i].br);
      #2;
      check($sformatf("vec%0d", i), outs, vecs[i].exp, vecs[i].mask);
    end

`ifdef HAZ_PERF_CNT_EN
    check32("stall_cnt", stall_cnt, 32'd1);
    check32("flush_cnt", flush_cnt, 32'd2);
    check32("fwd_cnt", fwd_cnt, 32'd7);
`endif

    // Async reset in the middle of FLUSH
    @(negedge clk);
    drive(1, 16, 1, 2, 1, 2'b00, 0, 0, 1);
    #2;
    check("br_run", outs, 9'b001100000, NOBUSY);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check("flush_before_rst", outs, 9'b001100001, FULL);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async", outs, 9'b0, FULL);
`ifdef HAZ_PERF_CNT_EN
    check32("stall_cnt_rst", stall_cnt, 32'd0);
    check32("flush_cnt_rst", flush_cnt, 32'd0);
    check32("fwd_cnt_rst", fwd_cnt, 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    check("rst_held", outs, 9'b0, FULL);
    rst_n = 1'b1;
    #2;
    check("rst_release", outs, 9'b0, FULL);
    @(negedge clk);
    drive(1, 3, 1, 2, 1, 2'b00, 0, 0, 0);
    #2;
    check("post_rst_add", outs, 9'b0, FULL);
    @(negedge clk);
    drive(1, 4, 3, 5, 1, 2'b00, 0, 0, 0);
    #2;
    check("post_rst_fwd", outs, 9'b000010000, FULL);
`ifdef HAZ_PERF_CNT_EN
    check32("fwd_cnt_post", fwd_cnt, 32'd0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    #2;
    check("post_rst_idle", outs, 9'b0, FULL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
